// File: rtl/byte_lane_arbiter.sv
// Two-requester round-robin arbiter that serializes accepted 32-bit words
// onto a registered byte stream, MSB first, with gap-free back-to-back words.
module byte_lane_arbiter #(
  parameter logic [7:0] IDLE_BYTE = 8'h00
) (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic [31:0] req0_data,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req1_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic        grant_id,
  output logic        busy
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  byte_cnt_reg, byte_cnt_next;
  logic        rr_reg, rr_next;
  logic [23:0] hold_reg, hold_next;
  logic [7:0]  data_reg, data_next;
  logic        valid_reg, valid_next;
  logic        grant_reg, grant_next;
  logic        busy_reg, busy_next;

  logic        window_open;
  logic        accept;
  logic        accept_id;
  logic [31:0] accept_word;

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      state_reg    <= IDLE;
      byte_cnt_reg <= 2'd0;
      rr_reg       <= 1'b0;
      hold_reg     <= 24'd0;
      data_reg     <= IDLE_BYTE;
      valid_reg    <= 1'b0;
      grant_reg    <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      byte_cnt_reg <= byte_cnt_next;
      rr_reg       <= rr_next;
      hold_reg     <= hold_next;
      data_reg     <= data_next;
      valid_reg    <= valid_next;
      grant_reg    <= grant_next;
      busy_reg     <= busy_next;
    end
  end

  // A new word may be taken while idle or while the last byte is showing.
  always_comb begin
    window_open = (state_reg == IDLE) || (state_reg == SEND && byte_cnt_reg == 2'd3);
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    if (!reset && window_open) begin
      req0_ready = req0_valid && (!req1_valid || !rr_reg);
      req1_ready = req1_valid && (!req0_valid || rr_reg);
    end
  end

  assign accept      = req0_ready | req1_ready;
  assign accept_id   = req1_ready;
  assign accept_word = accept_id ? req1_data : req0_data;

  always_comb begin
    state_next    = state_reg;
    byte_cnt_next = byte_cnt_reg;
    rr_next       = rr_reg;
    hold_next     = hold_reg;
    data_next     = data_reg;
    valid_next    = valid_reg;
    grant_next    = grant_reg;
    busy_next     = busy_reg;
    if (accept) begin
      state_next    = SEND;
      byte_cnt_next = 2'd0;
      rr_next       = ~accept_id;
      hold_next     = accept_word[23:0];
      data_next     = accept_word[31:24];
      valid_next    = 1'b1;
      grant_next    = accept_id;
      busy_next     = 1'b1;
    end else if (state_reg == SEND) begin
      if (byte_cnt_reg == 2'd3) begin
        state_next    = IDLE;
        byte_cnt_next = 2'd0;
        data_next     = IDLE_BYTE;
        valid_next    = 1'b0;
        grant_next    = 1'b0;
        busy_next     = 1'b0;
      end else begin
        byte_cnt_next = byte_cnt_reg + 2'd1;
        data_next     = hold_reg[23:16];
        hold_next     = {hold_reg[15:0], 8'h00};
      end
    end
  end

  assign data_out  = data_reg;
  assign valid_out = valid_reg;
  assign grant_id  = grant_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_byte_lane_arbiter.sv
// Directed self-checking bench for byte_lane_arbiter; inputs change and
// outputs are sampled on the falling edge of clk_4f.
module tb_byte_lane_arbiter;

  logic        clk_4f = 1'b0;
  logic        reset;
  logic [31:0] req0_data, req1_data;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [7:0]  data_out;
  logic        valid_out, grant_id, busy;

  int checks   = 0;
  int failures = 0;

  byte_lane_arbiter #(.IDLE_BYTE(8'h00)) dut (
    .clk_4f     (clk_4f),
    .reset      (reset),
    .req0_data  (req0_data),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req1_data  (req1_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  always #5 clk_4f = ~clk_4f;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic test_reset();
    reset = 1'b1;
    req0_data = 32'h12345678; req0_valid = 1'b1;
    req1_data = 32'h9ABCDEF0; req1_valid = 1'b1;
    @(negedge clk_4f);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      failures++;
      $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
    end
    checks++;
    if ({valid_out, grant_id, busy, data_out} !== {3'b000, 8'h00}) begin
      failures++;
      $display("FAIL reset_outputs: got v%b g%b b%b d%h expected v0 g0 b0 d00",
               valid_out, grant_id, busy, data_out);
    end
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    $display("reset: outputs idle, readies held low");
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_4f);
      checks++;
      if ({valid_out, grant_id, busy, data_out} !== {3'b000, 8'h00}) begin
        failures++;
        $display("FAIL idle_cycle%0d: got v%b g%b b%b d%h expected v0 g0 b0 d00",
                 i, valid_out, grant_id, busy, data_out);
      end
    end
    $display("idle: 10 cycles checked");
  endtask

  task automatic test_single_word();
    logic [7:0] exp_b [4];
    exp_b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    @(negedge clk_4f);
    req0_data = 32'hA1B2C3D4; req0_valid = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++;
      $display("FAIL single_ready: got %b expected 10", {req0_ready, req1_ready});
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_4f);
      if (k == 0) req0_valid = 1'b0;
      checks++;
      if ({valid_out, grant_id, busy, data_out} !== {3'b101, exp_b[k]}) begin
        failures++;
        $display("FAIL single_byte%0d: got v%b g%b b%b d%h expected v1 g0 b1 d%h",
                 k, valid_out, grant_id, busy, data_out, exp_b[k]);
      end
    end
    @(negedge clk_4f);
    checks++;
    if ({valid_out, grant_id, busy, data_out} !== {3'b000, 8'h00}) begin
      failures++;
      $display("FAIL single_end: got v%b g%b b%b d%h expected v0 g0 b0 d00",
               valid_out, grant_id, busy, data_out);
    end
    $display("single_word: A1B2C3D4 from req0");
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [8];
    int ready_cnt;
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    ready_cnt = 0;
    @(negedge clk_4f);
    req1_data = 32'h11223344; req1_valid = 1'b1;
    #1;
    if (req1_ready) ready_cnt++;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_4f);
      checks++;
      if ({valid_out, grant_id, busy, data_out} !== {3'b111, exp_b[i]}) begin
        failures++;
        $display("FAIL b2b_byte%0d: got v%b g%b b%b d%h expected v1 g1 b1 d%h",
                 i, valid_out, grant_id, busy, data_out, exp_b[i]);
      end
      if (i == 0) req1_data = 32'h55667788;
      if (i == 4) req1_valid = 1'b0;
      #1;
      if (req1_ready) ready_cnt++;
    end
    @(negedge clk_4f);
    checks++;
    if ({valid_out, busy, data_out} !== {2'b00, 8'h00}) begin
      failures++;
      $display("FAIL b2b_end: got v%b b%b d%h expected v0 b0 d00", valid_out, busy, data_out);
    end
    checks++;
    if (ready_cnt !== 2) begin
      failures++;
      $display("FAIL b2b_ready_edges: got %0d expected 2", ready_cnt);
    end
    $display("back_to_back: 11223344 then 55667788 from req1");
  endtask

  task automatic test_valid_drop();
    logic [7:0] exp_b [4];
    exp_b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    @(negedge clk_4f);
    req0_data = 32'hDEADBEEF; req0_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_4f);
      if (k == 0) req0_valid = 1'b0;
      checks++;
      if ({valid_out, grant_id, busy, data_out} !== {3'b101, exp_b[k]}) begin
        failures++;
        $display("FAIL drop_byte%0d: got v%b g%b b%b d%h expected v1 g0 b1 d%h",
                 k, valid_out, grant_id, busy, data_out, exp_b[k]);
      end
    end
    @(negedge clk_4f);
    checks++;
    if ({valid_out, busy, data_out} !== {2'b00, 8'h00}) begin
      failures++;
      $display("FAIL drop_end: got v%b b%b d%h expected v0 b0 d00", valid_out, busy, data_out);
    end
    $display("valid_drop: DEADBEEF sent whole after valid drop");
  endtask

  task automatic test_reset_midword();
    logic [7:0] exp_b [4];
    exp_b = '{8'h01, 8'h02, 8'h03, 8'h04};
    @(negedge clk_4f);
    req0_data = 32'h01020304; req0_valid = 1'b1;
    @(negedge clk_4f);
    req0_valid = 1'b0;
    @(negedge clk_4f);
    checks++;
    if ({valid_out, data_out} !== {1'b1, 8'h02}) begin
      failures++;
      $display("FAIL rstmid_byte1: got v%b d%h expected v1 d02", valid_out, data_out);
    end
    reset = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; req1_data = 32'hCAFEF00D;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      failures++;
      $display("FAIL rstmid_ready: got %b expected 00", {req0_ready, req1_ready});
    end
    @(negedge clk_4f);
    checks++;
    if ({valid_out, grant_id, busy, data_out} !== {3'b000, 8'h00}) begin
      failures++;
      $display("FAIL rstmid_outputs: got v%b g%b b%b d%h expected v0 g0 b0 d00",
               valid_out, grant_id, busy, data_out);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++;
      $display("FAIL rstmid_rr: got %b expected 10", {req0_ready, req1_ready});
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_4f);
      if (k == 0) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      checks++;
      if ({valid_out, grant_id, busy, data_out} !== {3'b101, exp_b[k]}) begin
        failures++;
        $display("FAIL rstmid_new%0d: got v%b g%b b%b d%h expected v1 g0 b1 d%h",
                 k, valid_out, grant_id, busy, data_out, exp_b[k]);
      end
    end
    @(negedge clk_4f);
    $display("reset_midword: word abandoned, rr restored, new word accepted");
  endtask

  task automatic test_contention();
    logic       g;
    logic [7:0] exp_d;
    logic [1:0] exp_rdy;
    @(negedge clk_4f);
    reset = 1'b1;
    @(negedge clk_4f);
    reset = 1'b0;
    req0_data = 32'hAAAAAAAA; req0_valid = 1'b1;
    req1_data = 32'hBBBBBBBB; req1_valid = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++;
      $display("FAIL cont_first_ready: got %b expected 10", {req0_ready, req1_ready});
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_4f);
      g = ((i / 4) % 2) == 1;
      exp_d = g ? 8'hBB : 8'hAA;
      checks++;
      if ({valid_out, grant_id, busy, data_out} !== {1'b1, g, 1'b1, exp_d}) begin
        failures++;
        $display("FAIL cont_byte%0d: got v%b g%b b%b d%h expected v1 g%b b1 d%h",
                 i, valid_out, grant_id, busy, data_out, g, exp_d);
      end
      if (i == 15) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      #1;
      exp_rdy = ((i % 4) == 3 && i != 15) ? (g ? 2'b10 : 2'b01) : 2'b00;
      checks++;
      if ({req0_ready, req1_ready} !== exp_rdy) begin
        failures++;
        $display("FAIL cont_ready%0d: got %b expected %b", i, {req0_ready, req1_ready}, exp_rdy);
      end
    end
    @(negedge clk_4f);
    checks++;
    if ({valid_out, grant_id, busy, data_out} !== {3'b000, 8'h00}) begin
      failures++;
      $display("FAIL cont_end: got v%b g%b b%b d%h expected v0 g0 b0 d00",
               valid_out, grant_id, busy, data_out);
    end
    $display("contention: grants alternated 0,1,0,1");
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_word();
    test_back_to_back();
    test_valid_drop();
    test_reset_midword();
    test_contention();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
